// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I constants and the B-type funct3 encoding.
package riscv_pkg;
   localparam int XLEN = 32;
   localparam int PC_STEP = 4;
   localparam logic [6:0] B_OPCODE = 7'b1100011;
   typedef enum logic [2:0] {
      BEQ  = 3'b000,
      BNE  = 3'b001,
      BLT  = 3'b100,
      BGE  = 3'b101,
      BLTU = 3'b110,
      BGEU = 3'b111
   } branch_instr;
endpackage

// File: rtl/instr_io.sv
// Instr_IO: port bus between the branch unit and whoever drives it.
interface Instr_IO #(parameter int XLEN = 32);
   logic clk;
   logic rst_n;
   logic [31:0] idata;
   logic [XLEN-1:0] iaddr;
   logic signed [XLEN-1:0] imm;
   logic signed [XLEN-1:0] rv1;
   logic signed [XLEN-1:0] rv2;
   logic [XLEN-1:0] iaddr_val;
   logic taken;
   logic illegal;
   logic misalign;
   logic [XLEN-1:0] iaddr_val_q;
   logic taken_q;
   logic illegal_q;
   logic misalign_q;
   modport dut (
      input clk, rst_n, idata, iaddr, imm, rv1, rv2,
      output iaddr_val, taken, illegal, misalign, iaddr_val_q, taken_q, illegal_q, misalign_q
   );
   modport driver (
      output clk, rst_n, idata, iaddr, imm, rv1, rv2,
      input iaddr_val, taken, illegal, misalign, iaddr_val_q, taken_q, illegal_q, misalign_q
   );
endinterface

// File: rtl/branch_cmp.sv
// branch_cmp: funct3 decode and rv1/rv2 comparison for conditional branches.
module branch_cmp
   import riscv_pkg::*;
(
   input  logic [2:0]             funct3,
   input  logic signed [XLEN-1:0] rv1,
   input  logic signed [XLEN-1:0] rv2,
   output logic                   taken,
   output logic                   illegal
);
   always_comb begin
      taken = 1'b0;
      illegal = 1'b0;
      // unknown funct3 falls into default and is treated as illegal
      case (funct3)
         BEQ:     taken = rv1 == rv2;
         BNE:     taken = rv1 != rv2;
         BLT:     taken = rv1 < rv2;
         BGE:     taken = rv1 >= rv2;
         BLTU:    taken = $unsigned(rv1) < $unsigned(rv2);
         BGEU:    taken = $unsigned(rv1) >= $unsigned(rv2);
         default: illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/b_type.sv
// b_type: RV32I branch resolution; combinational next PC plus a registered copy.
module b_type
   import riscv_pkg::*;
(
   Instr_IO.dut io
);
   logic [XLEN-1:0] target;
   logic            taken;
   logic            illegal;
   logic            misalign;
   logic [XLEN-1:0] next_pc;
   branch_cmp u_cmp (
      .funct3  (io.idata[14:12]),
      .rv1     (io.rv1),
      .rv2     (io.rv2),
      .taken   (taken),
      .illegal (illegal)
   );
   assign target = io.iaddr + $unsigned(io.imm);
   // an unaligned target is only flagged, never corrected
   assign misalign = taken & (|target[1:0]);
   assign next_pc = taken ? target : io.iaddr + XLEN'(PC_STEP);
   assign io.iaddr_val = next_pc;
   assign io.taken = taken;
   assign io.illegal = illegal;
   assign io.misalign = misalign;
   always_ff @(posedge io.clk or negedge io.rst_n) begin
      if (!io.rst_n) begin
         io.iaddr_val_q <= '0;
         io.taken_q <= 1'b0;
         io.illegal_q <= 1'b0;
         io.misalign_q <= 1'b0;
      end else begin
         io.iaddr_val_q <= next_pc;
         io.taken_q <= taken;
         io.illegal_q <= illegal;
         io.misalign_q <= misalign;
      end
   end
endmodule

// File: tb/tb_b_type.sv
// tb_b_type: directed checks of the branch unit's combinational and registered outputs.
module tb_b_type;
   import riscv_pkg::*;
   Instr_IO bus ();
   b_type dut (.io(bus));
   int total = 0;
   int bad = 0;
   initial bus.clk = 1'b0;
   always #5 bus.clk = ~bus.clk;

   task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] i,
                        input logic [31:0] r1, input logic [31:0] r2);
      bus.idata = {17'b0, f3, 5'b0, B_OPCODE};
      bus.iaddr = a;
      bus.imm = i;
      bus.rv1 = r1;
      bus.rv2 = r2;
      #1;
   endtask

   task automatic test_reset;
      bus.rst_n = 1'b0;
      drive(BEQ, 32'h0, 32'h10, 32'd1, 32'd1);
      total++; if (bus.iaddr_val_q !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", bus.iaddr_val_q); end
      total++; if (bus.taken_q !== 1'b0) begin bad++; $display("FAIL reset_taken got=%b exp=0", bus.taken_q); end
      @(posedge bus.clk); #1;
      total++; if ({bus.taken_q, bus.illegal_q, bus.misalign_q} !== 3'b000 || bus.iaddr_val_q !== 32'h0) begin
         bad++; $display("FAIL reset_hold got=%h/%b%b%b exp=0", bus.iaddr_val_q, bus.taken_q, bus.illegal_q, bus.misalign_q);
      end
      total++; if (bus.iaddr_val !== 32'h10) begin bad++; $display("FAIL reset_comb got=%h exp=00000010", bus.iaddr_val); end
      @(negedge bus.clk);
      bus.rst_n = 1'b1;
   endtask

   task automatic test_beq;
      drive(BEQ, 32'h0, 32'hFF, 32'd10, 32'd10);
      total++; if (bus.iaddr_val !== 32'hFF || bus.taken !== 1'b1) begin bad++; $display("FAIL beq_eq got=%h/%b exp=000000ff/1", bus.iaddr_val, bus.taken); end
      drive(BEQ, 32'h0, 32'hFF, 32'd5, 32'd10);
      total++; if (bus.iaddr_val !== 32'h4 || bus.taken !== 1'b0) begin bad++; $display("FAIL beq_ne got=%h/%b exp=00000004/0", bus.iaddr_val, bus.taken); end
   endtask

   task automatic test_bne;
      drive(BNE, 32'h0, 32'hFF, 32'd10, 32'd10);
      total++; if (bus.iaddr_val !== 32'h4) begin bad++; $display("FAIL bne_eq got=%h exp=00000004", bus.iaddr_val); end
      drive(BNE, 32'h0, 32'hFF, 32'd5, 32'd10);
      total++; if (bus.iaddr_val !== 32'hFF) begin bad++; $display("FAIL bne_ne got=%h exp=000000ff", bus.iaddr_val); end
   endtask

   task automatic test_signed;
      drive(BLT, 32'h0, 32'hFF, 32'd10, 32'd15);
      total++; if (bus.iaddr_val !== 32'hFF) begin bad++; $display("FAIL blt_lt got=%h exp=000000ff", bus.iaddr_val); end
      drive(BLT, 32'h0, 32'hFF, 32'd10, -32'sd15);
      total++; if (bus.iaddr_val !== 32'h4) begin bad++; $display("FAIL blt_neg got=%h exp=00000004", bus.iaddr_val); end
      drive(BGE, 32'h0, 32'hFF, 32'd10, -32'sd15);
      total++; if (bus.iaddr_val !== 32'hFF) begin bad++; $display("FAIL bge_neg got=%h exp=000000ff", bus.iaddr_val); end
      total++; if (bus.misalign !== 1'b1) begin bad++; $display("FAIL bge_misalign got=%b exp=1", bus.misalign); end
      drive(BGE, 32'h0, 32'hFF, 32'd10, 32'd15);
      total++; if (bus.iaddr_val !== 32'h4 || bus.misalign !== 1'b0) begin bad++; $display("FAIL bge_lt got=%h/%b exp=00000004/0", bus.iaddr_val, bus.misalign); end
   endtask

   task automatic test_unsigned;
      drive(BGEU, 32'h0, 32'hFF, 32'd10, 32'd5);
      total++; if (bus.iaddr_val !== 32'hFF) begin bad++; $display("FAIL bgeu got=%h exp=000000ff", bus.iaddr_val); end
      drive(BLTU, 32'h0, 32'hFF, 32'd10, 32'd5);
      total++; if (bus.iaddr_val !== 32'h4) begin bad++; $display("FAIL bltu_gt got=%h exp=00000004", bus.iaddr_val); end
      drive(BLTU, 32'h0, 32'hFF, 32'd10, 32'hFFFFFFF1);
      total++; if (bus.iaddr_val !== 32'hFF) begin bad++; $display("FAIL bltu_big got=%h exp=000000ff", bus.iaddr_val); end
   endtask

   task automatic test_boundary;
      drive(BEQ, 32'h100, 32'h8, 32'h80000000, 32'h80000000);
      total++; if (bus.taken !== 1'b1 || bus.iaddr_val !== 32'h108) begin bad++; $display("FAIL bnd_beq got=%b/%h exp=1/00000108", bus.taken, bus.iaddr_val); end
      drive(BGE, 32'h100, 32'h8, 32'h80000000, 32'h80000000);
      total++; if (bus.taken !== 1'b1) begin bad++; $display("FAIL bnd_bge got=%b exp=1", bus.taken); end
      drive(BLT, 32'h100, 32'h8, 32'h80000000, 32'h80000000);
      total++; if (bus.taken !== 1'b0 || bus.iaddr_val !== 32'h104) begin bad++; $display("FAIL bnd_blt got=%b/%h exp=0/00000104", bus.taken, bus.iaddr_val); end
      drive(BLT, 32'h100, 32'h8, 32'h7FFFFFFF, 32'h80000000);
      total++; if (bus.taken !== 1'b0) begin bad++; $display("FAIL bnd_blt_max got=%b exp=0", bus.taken); end
      drive(BLTU, 32'h100, 32'h8, 32'h7FFFFFFF, 32'h80000000);
      total++; if (bus.taken !== 1'b1) begin bad++; $display("FAIL bnd_bltu_max got=%b exp=1", bus.taken); end
   endtask

   task automatic test_wrap;
      drive(BNE, 32'hFFFFFFFC, 32'h40, 32'd3, 32'd3);
      total++; if (bus.iaddr_val !== 32'h0) begin bad++; $display("FAIL wrap_fall got=%h exp=00000000", bus.iaddr_val); end
      drive(BEQ, 32'hFFFFFFF0, 32'h20, 32'd3, 32'd3);
      total++; if (bus.iaddr_val !== 32'h10) begin bad++; $display("FAIL wrap_target got=%h exp=00000010", bus.iaddr_val); end
      drive(BEQ, 32'h1000, 32'hFFFFFFF8, 32'd0, 32'd0);
      total++; if (bus.iaddr_val !== 32'hFF8 || bus.misalign !== 1'b0) begin bad++; $display("FAIL neg_imm got=%h/%b exp=00000ff8/0", bus.iaddr_val, bus.misalign); end
   endtask

   task automatic test_illegal;
      drive(3'b010, 32'h100, 32'h8, 32'd7, 32'd7);
      total++; if (bus.illegal !== 1'b1 || bus.taken !== 1'b0 || bus.iaddr_val !== 32'h104) begin
         bad++; $display("FAIL illegal_010 got=%b/%b/%h exp=1/0/00000104", bus.illegal, bus.taken, bus.iaddr_val);
      end
      drive(3'b011, 32'h200, 32'h8, 32'd1, 32'd2);
      total++; if (bus.illegal !== 1'b1 || bus.iaddr_val !== 32'h204) begin bad++; $display("FAIL illegal_011 got=%b/%h exp=1/00000204", bus.illegal, bus.iaddr_val); end
      drive(BGEU, 32'h200, 32'h8, 32'd1, 32'd2);
      total++; if (bus.illegal !== 1'b0) begin bad++; $display("FAIL legal_bgeu got=%b exp=0", bus.illegal); end
   endtask

   task automatic test_registered;
      @(negedge bus.clk);
      drive(BGE, 32'h1000, 32'h11, 32'd3, 32'd3);
      @(posedge bus.clk); #1;
      total++; if (bus.iaddr_val_q !== 32'h1011 || bus.taken_q !== 1'b1 || bus.misalign_q !== 1'b1 || bus.illegal_q !== 1'b0) begin
         bad++; $display("FAIL reg_cap got=%h/%b%b%b exp=00001011/101", bus.iaddr_val_q, bus.taken_q, bus.illegal_q, bus.misalign_q);
      end
      drive(3'b010, 32'h300, 32'h8, 32'd0, 32'd0);
      total++; if (bus.iaddr_val_q !== 32'h1011 || bus.illegal_q !== 1'b0) begin bad++; $display("FAIL reg_hold got=%h/%b exp=00001011/0", bus.iaddr_val_q, bus.illegal_q); end
      @(posedge bus.clk); #1;
      total++; if (bus.iaddr_val_q !== 32'h304 || bus.illegal_q !== 1'b1 || bus.taken_q !== 1'b0) begin
         bad++; $display("FAIL reg_next got=%h/%b/%b exp=00000304/1/0", bus.iaddr_val_q, bus.illegal_q, bus.taken_q);
      end
   endtask

   task automatic test_reset_mid;
      drive(BEQ, 32'h2000, 32'h20, 32'd9, 32'd9);
      @(posedge bus.clk); #1;
      total++; if (bus.iaddr_val_q !== 32'h2020 || bus.taken_q !== 1'b1) begin bad++; $display("FAIL mid_pre got=%h/%b exp=00002020/1", bus.iaddr_val_q, bus.taken_q); end
      @(negedge bus.clk);
      bus.rst_n = 1'b0;
      #1;
      total++; if (bus.iaddr_val_q !== 32'h0 || bus.taken_q !== 1'b0 || bus.illegal_q !== 1'b0 || bus.misalign_q !== 1'b0) begin
         bad++; $display("FAIL mid_clear got=%h/%b%b%b exp=0", bus.iaddr_val_q, bus.taken_q, bus.illegal_q, bus.misalign_q);
      end
      total++; if (bus.iaddr_val !== 32'h2020 || bus.taken !== 1'b1) begin bad++; $display("FAIL mid_comb got=%h/%b exp=00002020/1", bus.iaddr_val, bus.taken); end
      @(posedge bus.clk); #1;
      total++; if (bus.iaddr_val_q !== 32'h0 || bus.taken_q !== 1'b0) begin bad++; $display("FAIL mid_hold got=%h/%b exp=0/0", bus.iaddr_val_q, bus.taken_q); end
      @(negedge bus.clk);
      bus.rst_n = 1'b1;
      drive(BLTU, 32'h400, 32'h22, 32'd1, 32'd2);
      total++; if (bus.iaddr_val_q !== 32'h0) begin bad++; $display("FAIL mid_release got=%h exp=0", bus.iaddr_val_q); end
      @(posedge bus.clk); #1;
      total++; if (bus.iaddr_val_q !== 32'h422 || bus.taken_q !== 1'b1 || bus.misalign_q !== 1'b1) begin
         bad++; $display("FAIL mid_resume got=%h/%b/%b exp=00000422/1/1", bus.iaddr_val_q, bus.taken_q, bus.misalign_q);
      end
   endtask

   initial begin
      test_reset();
      test_beq();
      test_bne();
      test_signed();
      test_unsigned();
      test_boundary();
      test_wrap();
      test_illegal();
      test_registered();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
